// File: rtl/sc_pkg.sv
// Shared types and width helpers for the stochastic dot-product accumulator.
package sc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } sc_state_e;

  typedef enum logic {
    SC_UNIPOLAR,
    SC_BIPOLAR
  } sc_mode_e;

  function automatic int unsigned sum_width(input int unsigned bitstream,
                                            input int unsigned acc_len);
    return $clog2(bitstream * acc_len + 1);
  endfunction

  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sc_popcount.sv
// Combinational ones count of a W-bit word.
module sc_popcount #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0]             bits,
  output logic [$clog2(W+1)-1:0]   count
);

  localparam int unsigned CW = $clog2(W + 1);

  always_comb begin
    count = '0;
    for (int unsigned i = 0; i < W; i++) begin
      count = count + CW'(bits[i]);
    end
  end

endmodule

// File: rtl/sc_dot_accumulator.sv
// Multiplies stochastic stream pairs bitwise and accumulates the product popcount
// CHUNK bits per cycle over a vector of pairs, returning the binary count.
module sc_dot_accumulator
  import sc_pkg::*;
#(
  parameter int unsigned BITSTREAM = 64,
  parameter int unsigned CHUNK     = 8,
  parameter int unsigned ACC_LEN   = 16,
  parameter bit          BIPOLAR   = 1'b0
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       iValid,
  output logic                                       oReady,
  input  logic [BITSTREAM-1:0]                       iStreamA,
  input  logic [BITSTREAM-1:0]                       iStreamB,
  input  logic                                       iLast,
  output logic                                       oValid,
  input  logic                                       iReady,
  output logic [sum_width(BITSTREAM, ACC_LEN)-1:0]   oSum,
  output logic [cnt_width(ACC_LEN)-1:0]              oPairs,
  output logic                                       oTrunc
);

  localparam int unsigned SUM_W  = sum_width(BITSTREAM, ACC_LEN);
  localparam int unsigned PAIR_W = cnt_width(ACC_LEN);
  localparam int unsigned NCHUNK = BITSTREAM / CHUNK;
  localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int unsigned PC_W   = cnt_width(CHUNK);
  localparam sc_mode_e    MODE   = BIPOLAR ? SC_BIPOLAR : SC_UNIPOLAR;

  if (BITSTREAM % CHUNK != 0) begin : g_chunk_check
    $fatal(1, "BITSTREAM must be a multiple of CHUNK");
  end

  sc_state_e             state;
  logic [BITSTREAM-1:0]  prod;
  logic                  last;
  logic [IDX_W-1:0]      idx;
  logic [SUM_W-1:0]      acc;
  logic [PAIR_W-1:0]     cnt;

  logic [BITSTREAM-1:0]  prod_in;
  logic [CHUNK-1:0]      chunk;
  logic [PC_W-1:0]       chunk_ones;
  logic [SUM_W-1:0]      acc_next;
  logic [PAIR_W-1:0]     cnt_next;
  logic                  last_chunk;
  logic                  full;

  // The product is formed once at accept time so SCAN only slices one register.
  always_comb begin
    prod_in    = (MODE == SC_BIPOLAR) ? ~(iStreamA ^ iStreamB) : (iStreamA & iStreamB);
    chunk      = prod[idx*CHUNK +: CHUNK];
    acc_next   = acc + SUM_W'(chunk_ones);
    cnt_next   = cnt + 1'b1;
    last_chunk = (idx == IDX_W'(NCHUNK - 1));
    full       = (cnt_next == PAIR_W'(ACC_LEN));
  end

  sc_popcount #(.W(CHUNK)) u_popcount (
    .bits  (chunk),
    .count (chunk_ones)
  );

  assign oReady = (state == IDLE);
  assign oValid = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      prod   <= '0;
      last   <= 1'b0;
      idx    <= '0;
      acc    <= '0;
      cnt    <= '0;
      oSum   <= '0;
      oPairs <= '0;
      oTrunc <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (iValid) begin
            prod  <= prod_in;
            last  <= iLast;
            idx   <= '0;
            state <= SCAN;
          end
        end
        SCAN: begin
          acc <= acc_next;
          idx <= idx + 1'b1;
          if (last_chunk) begin
            cnt <= cnt_next;
            if (last || full) begin
              oSum   <= acc_next;
              oPairs <= cnt_next;
              oTrunc <= !last && full;
              state  <= DONE;
            end else begin
              state <= IDLE;
            end
          end
        end
        DONE: begin
          if (iReady) begin
            acc   <= '0;
            cnt   <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
